// File: rtl/waveform_player.sv
// Steps buffered waveform samples out to the AD5791 SPI master, one framed
// write per sample, with a programmable idle gap and optional looping.
module waveform_player #(
    parameter int unsigned         WORD_WID  = 20,
    parameter int unsigned         DAC_WID   = 24,
    parameter int unsigned         CMD_WID   = 4,
    parameter logic [CMD_WID-1:0]  DAC_CMD   = 4'b0001,
    parameter int unsigned         TIMER_WID = 32,
    parameter int unsigned         INDEX_WID = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 do_loop,
    input  logic [TIMER_WID-1:0] time_to_wait,
    output logic                 ready,
    output logic                 finished,
    output logic [INDEX_WID-1:0] cur_index,
    input  logic [WORD_WID-1:0]  word,
    input  logic                 word_ok,
    input  logic                 word_last,
    output logic                 word_next,
    output logic                 word_rst,
    output logic [DAC_WID-1:0]   dac_out,
    output logic                 dac_arm,
    input  logic                 dac_finished
);

    typedef enum logic [2:0] {
        IDLE,
        REWIND,
        WAIT_WORD,
        ARM_DAC,
        WAIT_TIMER,
        ADVANCE,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic                   finished_q;
    logic                   word_next_q;
    logic                   word_rst_q;
    logic                   dac_arm_q;
    logic [DAC_WID-1:0]     dac_out_q;
    logic [INDEX_WID-1:0]   index_q;
    logic [TIMER_WID-1:0]   t_lat_q;
    logic [TIMER_WID-1:0]   timer_q;
    logic                   last_q;
    logic                   stop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            finished_q  <= 1'b0;
            word_next_q <= 1'b0;
            word_rst_q  <= 1'b0;
            dac_arm_q   <= 1'b0;
            dac_out_q   <= '0;
            index_q     <= '0;
            t_lat_q     <= '0;
            timer_q     <= '0;
            last_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            word_next_q <= 1'b0;
            word_rst_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        t_lat_q    <= time_to_wait;
                        word_rst_q <= 1'b1;
                        index_q    <= '0;
                        ready_q    <= 1'b0;
                        state_q    <= REWIND;
                    end
                end
                // Settle cycle: the buffer is still dropping its stale word_ok.
                REWIND, ADVANCE: begin
                    if (!run) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_WORD;
                    end
                end
                WAIT_WORD: begin
                    if (!run) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (word_ok) begin
                        dac_out_q <= {DAC_CMD, word};
                        last_q    <= word_last;
                        dac_arm_q <= 1'b1;
                        stop_q    <= 1'b0;
                        state_q   <= ARM_DAC;
                    end
                end
                // A stop request is remembered so the SPI transfer is never cut short.
                ARM_DAC: begin
                    if (!run) begin
                        stop_q <= 1'b1;
                    end
                    if (dac_finished) begin
                        dac_arm_q <= 1'b0;
                        timer_q   <= '0;
                        if (stop_q || !run) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT_TIMER;
                        end
                    end
                end
                WAIT_TIMER: begin
                    if (!run) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (timer_q == t_lat_q) begin
                        if (!last_q) begin
                            word_next_q <= 1'b1;
                            index_q     <= index_q + INDEX_WID'(1);
                            state_q     <= ADVANCE;
                        end else if (do_loop) begin
                            word_rst_q <= 1'b1;
                            index_q    <= '0;
                            state_q    <= REWIND;
                        end else begin
                            finished_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_WID'(1);
                    end
                end
                DONE: begin
                    if (!run) begin
                        finished_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    ready_q    <= 1'b1;
                    finished_q <= 1'b0;
                    dac_arm_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign finished  = finished_q;
    assign word_next = word_next_q;
    assign word_rst  = word_rst_q;
    assign dac_arm   = dac_arm_q;
    assign dac_out   = dac_out_q;
    assign cur_index = index_q;

endmodule

// File: tb/tb_waveform_player.sv
// Randomized bench for waveform_player: a buffer and SPI responder drive the
// DUT while a transaction-level playback model predicts every sample.
module tb_waveform_player;

    localparam logic [3:0] CMD = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        do_loop = 1'b0;
    logic [31:0] time_to_wait = '0;
    logic        ready, finished;
    logic [10:0] cur_index;
    logic [19:0] word = '0;
    logic        word_ok = 1'b0;
    logic        word_last = 1'b0;
    logic        word_next, word_rst;
    logic [23:0] dac_out;
    logic        dac_arm;
    logic        dac_finished = 1'b0;

    waveform_player #(
        .WORD_WID  (20),
        .DAC_WID   (24),
        .CMD_WID   (4),
        .DAC_CMD   (4'b0001),
        .TIMER_WID (32),
        .INDEX_WID (11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .do_loop      (do_loop),
        .time_to_wait (time_to_wait),
        .ready        (ready),
        .finished     (finished),
        .cur_index    (cur_index),
        .word         (word),
        .word_ok      (word_ok),
        .word_last    (word_last),
        .word_next    (word_next),
        .word_rst     (word_rst),
        .dac_out      (dac_out),
        .dac_arm      (dac_arm),
        .dac_finished (dac_finished)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    logic [19:0] mem [16];
    int n_words, ptr, ok_cnt, ok_delay, spi_delay, t_cfg;
    bit loop_m;
    int cyc = 0;
    int fin_at = -1;
    int last_fin = -1;
    int pulse_cyc = 0;
    int exp_pos, samples, n_next, n_rst;
    bit start_pending, stopped;
    bit prev_arm = 1'b0;
    bit prev_fin = 1'b0;
    logic [23:0] arm_word;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_ready"},    32'(ready), 1);
        check_eq({tag, "_finished"}, 32'(finished), 0);
        check_eq({tag, "_next"},     32'(word_next), 0);
        check_eq({tag, "_rst"},      32'(word_rst), 0);
        check_eq({tag, "_arm"},      32'(dac_arm), 0);
        check_eq({tag, "_dac_out"},  32'(dac_out), 0);
        check_eq({tag, "_index"},    32'(cur_index), 0);
    endtask

    // Observe one cycle's outputs, update the playback model, then drive the
    // buffer and SPI responses seen by the DUT during this cycle.
    task automatic monitor();
        int lat;
        lat = (ok_delay + 1 > 2) ? ok_delay + 1 : 2;
        check_eq("pulse_excl", 32'(word_next & word_rst), 0);
        if (stopped) check_eq("pulse_after_stop", 32'(word_next | word_rst), 0);

        if (word_rst) begin
            if (start_pending) begin
                start_pending = 1'b0;
                time_to_wait = $urandom;
            end else begin
                check_eq("rst_on_last", 32'(exp_pos == n_words - 1 && loop_m), 1);
                check_eq("rst_timing", 32'(cyc - last_fin), 32'(t_cfg + 2));
                n_rst++;
            end
            exp_pos = 0;
            check_eq("rst_index", 32'(cur_index), 0);
            pulse_cyc = cyc;
        end
        if (word_next) begin
            check_eq("next_order", 32'(!start_pending && exp_pos < n_words - 1), 1);
            check_eq("next_timing", 32'(cyc - last_fin), 32'(t_cfg + 2));
            exp_pos++;
            n_next++;
            check_eq("next_index", 32'(cur_index), 32'(exp_pos));
            pulse_cyc = cyc;
        end
        if (finished && !prev_fin) begin
            check_eq("done_on_last", 32'(exp_pos == n_words - 1 && !loop_m), 1);
            check_eq("done_timing", 32'(cyc - last_fin), 32'(t_cfg + 2));
        end

        if (dac_arm && !prev_arm) begin
            check_eq("arm_after_stop", 32'(stopped), 0);
            check_eq("arm_needs_ok", 32'(word_ok), 1);
            check_eq("arm_latency", 32'(cyc - pulse_cyc), 32'(lat));
            check_eq("dac_word", 32'(dac_out), 32'({CMD, mem[exp_pos & 15]}));
            check_eq("arm_index", 32'(cur_index), 32'(exp_pos));
            arm_word = dac_out;
            fin_at = cyc + spi_delay;
            samples++;
        end else if (fin_at >= 0 && cyc <= fin_at) begin
            check_eq("arm_hold", 32'(dac_arm), 1);
            check_eq("dac_stable", 32'(dac_out), 32'(arm_word));
        end else if (fin_at >= 0 && cyc == fin_at + 1) begin
            check_eq("arm_drop", 32'(dac_arm), 0);
            check_eq("dac_stable_after", 32'(dac_out), 32'(arm_word));
        end
        dac_finished = (fin_at >= 0 && cyc == fin_at);
        if (dac_finished) last_fin = cyc;

        if (word_rst) begin
            ptr = 0;
            ok_cnt = ok_delay;
        end else if (word_next) begin
            if (ptr < n_words - 1) ptr++;
            ok_cnt = ok_delay;
        end else if (ok_cnt > 0) begin
            ok_cnt--;
        end
        word = mem[ptr];
        word_last = (ptr == n_words - 1);
        word_ok = (ok_cnt == 0);

        prev_arm = dac_arm;
        prev_fin = finished;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic start_play(input int nw, input int tw, input bit lp, input int okd,
                              input int spid, input bit fixed);
        n_words = nw;
        for (int i = 0; i < 16; i++) mem[i] = fixed ? 20'(i + 1) : 20'($urandom);
        t_cfg = tw;
        loop_m = lp;
        ok_delay = okd;
        spi_delay = spid;
        exp_pos = 0;
        samples = 0;
        n_next = 0;
        n_rst = 0;
        start_pending = 1'b1;
        stopped = 1'b0;
        fin_at = -1;
        time_to_wait = 32'(tw);
        do_loop = lp;
        ptr = 0;
        ok_cnt = 0;
        word = mem[0];
        word_last = (nw == 1);
        word_ok = 1'b1;
        run = 1'b1;
    endtask

    task automatic stop_and_idle();
        int exp_rdy;
        int g;
        exp_rdy = (fin_at >= 0 && cyc <= fin_at) ? fin_at + 1 : cyc + 1;
        run = 1'b0;
        stopped = 1'b1;
        g = 0;
        do begin
            cycle();
            g++;
        end while (!ready && g < 200);
        check_eq("stop_to_idle", 32'(cyc), 32'(exp_rdy));
        check_eq("idle_finished", 32'(finished), 0);
        check_eq("idle_arm", 32'(dac_arm), 0);
    endtask

    task automatic episode(input int nw, input int tw, input bit lp, input int okd,
                           input int spid, input int max_s, input int stop_dly, input bit fixed);
        int g;
        start_play(nw, tw, lp, okd, spid, fixed);
        g = 0;
        while (!finished && samples < max_s && g < 5000) begin
            cycle();
            g++;
        end
        check_eq("play_timeout", 32'(g < 5000), 1);
        if (finished) begin
            check_eq("done_index", 32'(cur_index), 32'(nw - 1));
            check_eq("done_samples", 32'(samples), 32'(nw));
            check_eq("done_nexts", 32'(n_next), 32'(nw - 1));
        end else begin
            repeat (stop_dly) cycle();
        end
        stop_and_idle();
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_reset_outs(tag);
        #2 rst = 1'b0;
        time_to_wait = 32'(t_cfg);
        dac_finished = 1'b0;
        fin_at = -1;
        prev_arm = 1'b0;
        prev_fin = 1'b0;
        exp_pos = 0;
        samples = 0;
        start_pending = 1'b1;
    endtask

    task automatic reset_test();
        int g;
        start_play(4, 3, 1'b1, 0, 6, 1'b1);
        g = 0;
        while (samples < 2 && g < 2000) begin
            cycle();
            g++;
        end
        while (cyc < fin_at + 2 && g < 2000) begin
            cycle();
            g++;
        end
        async_reset("rst_timer");
        while (samples < 1 && g < 2000) begin
            cycle();
            g++;
        end
        repeat (2) cycle();
        async_reset("rst_arm");
        while (samples < 3 && g < 2000) begin
            cycle();
            g++;
        end
        check_eq("rst_test_timeout", 32'(g < 2000), 1);
        stop_and_idle();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("por");
        rst = 1'b0;

        episode(4, 5, 1'b0, 0, 10, 1000, 0, 1'b1);   // single shot
        episode(4, 5, 1'b1, 0, 10, 10, 0, 1'b1);     // loop, 10 samples
        episode(4, 2, 1'b1, 0, 10, 2, 2, 1'b0);      // stop mid-transfer
        episode(5, 1, 1'b0, 20, 3, 1000, 0, 1'b0);   // slow buffer
        episode(3, 0, 1'b0, 1, 2, 1000, 0, 1'b0);    // zero wait
        for (int i = 0; i < 10; i++) begin
            episode($urandom_range(1, 8), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), $urandom_range(1, 8), $urandom_range(1, 20),
                    $urandom_range(0, 10), 1'b0);
        end
        reset_test();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
